result_uart_tx: RTL and testbench



---
 rtl/result_uart_tx.sv | 220 ++++++++++++++++++++++
 tb/tb_result_uart_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_uart_tx.sv
// Result serializer: buffers each compute-FSM result byte and sends it as an asynchronous serial frame on tx.
// Latency: a strobe in cycle N is counted after edge N, popped in N+1, and the start bit appears at edge N+2.
// Backpressure: none toward the producer; a strobe that meets a full FIFO is dropped and sets the sticky overflow flag.
// Optional feature: define RESULT_UART_TX_PARITY_EN to add an even-parity bit after data bit 7 (11*DIV-cycle frame).
module result_uart_tx #(
  parameter int DIV   = 16,  // clock cycles per serial bit, 2..65535
  parameter int DEPTH = 4    // FIFO entries, power of two, >= 2
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [7:0]               din,
  input  logic                     din_valid,
  input  logic                     clr_overflow,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RESULT_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  // Transmitter state
  state_e        state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic          full;
  logic          push;
  logic          drop;
  logic          pop;
  logic          bit_end;
  logic [7:0]    head;

  // Push/pop decisions are made from the registered count only, so a pop
  // in the same cycle never makes room for a write that arrived at full.
  always_comb begin
    full    = (count_q == CW'(DEPTH));
    push    = din_valid && !full;
    drop    = din_valid && full;
    pop     = (state_q == IDLE) && (count_q != '0);
    head    = mem[rd_ptr_q];
    bit_end = (baud_q == 16'(DIV - 1));
  end

  // FIFO pointer, occupancy and sticky overflow next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A drop wins over a coincident clear so no loss goes unreported.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_overflow) begin
      ovf_d = 1'b0;
    end
  end

  // Frame sequencer: each bit period is DIV cycles counted by baud_q
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (pop) begin
          shift_d = head;
          par_d   = ^head;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef RESULT_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`ifdef RESULT_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Line level follows the current state; registering it delays the line
  // by one cycle relative to the state, which keeps every bit DIV wide.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
`ifdef RESULT_UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  // FIFO data array; no reset needed since the pointers define validity
  always_ff @(posedge sys_clk) begin
    if (push && !sys_rst) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // State registers with synchronous reset; reset aborts any frame in flight
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx with DIV=4, DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected line levels come from the byte values and the frame format.
module tb_result_uart_tx;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
`ifdef RESULT_UART_TX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [7:0] din;
  logic       din_valid;
  logic       clr_overflow;
  logic       tx;
  logic       busy;
  logic [$clog2(DEPTH):0] fifo_count;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  result_uart_tx #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .din          (din),
    .din_valid    (din_valid),
    .clr_overflow (clr_overflow),
    .tx           (tx),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected line level for slot s of a frame carrying byte b
  function automatic logic slot_level(input logic [7:0] b, input int s);
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
`ifdef RESULT_UART_TX_PARITY_EN
    if (s == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Wait (bounded) for the start bit, then check every slot is DIV cycles at
  // the right level. waited = falling edges advanced before the start bit.
  task automatic expect_frame(input logic [7:0] b, input string tag, output int waited);
    logic [DIV-1:0] pat;
    logic [DIV-1:0] exp;
    waited = 0;
    while (tx !== 1'b0 && waited < 300) begin
      @(negedge sys_clk);
      waited++;
    end
    if (tx !== 1'b0) begin
      check($sformatf("%s start timeout", tag), 32'd0, 32'd1);
      return;
    end
    check($sformatf("%s busy in frame", tag), 32'(busy), 32'd1);
    for (int s = 0; s < NSLOT; s++) begin
      for (int i = 0; i < DIV; i++) begin
        if (!(s == 0 && i == 0)) @(negedge sys_clk);
        pat[i] = tx;
      end
      exp = slot_level(b, s) ? '1 : '0;
      check($sformatf("%s slot%0d", tag, s), 32'(pat), 32'(exp));
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    din       = b;
    din_valid = 1'b1;
    @(negedge sys_clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge sys_clk);
      n++;
    end
    check($sformatf("%s idle", tag), 32'(busy), 32'd0);
  endtask

  initial begin
    int w;
    int peak;
    int lows;
    int busys;
    logic [7:0] vals [2];

    sys_rst      = 1'b1;
    din          = 8'h00;
    din_valid    = 1'b0;
    clr_overflow = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst tx", 32'(tx), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst count", 32'(fifo_count), 32'd0);
    check("rst ovf", 32'(overflow), 32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Single 0x07 with exact latency
    strobe(8'h07);
    check("t1 count after push", 32'(fifo_count), 32'd1);
    check("t1 tx idle", 32'(tx), 32'd1);
    @(negedge sys_clk);
    check("t1 count after pop", 32'(fifo_count), 32'd0);
    check("t1 tx before start", 32'(tx), 32'd1);
    check("t1 busy", 32'(busy), 32'd1);
    expect_frame(8'h07, "t1", w);
    check("t1 latency", 32'(w), 32'd1);
    check("t1 busy after stop", 32'(busy), 32'd0);
    @(negedge sys_clk);
    check("t1 tx after frame", 32'(tx), 32'd1);

    // More single frames
    vals[0] = 8'h03;
    vals[1] = 8'hA5;
    for (int k = 0; k < 2; k++) begin
      repeat (3) @(negedge sys_clk);
      strobe(vals[k]);
      expect_frame(vals[k], $sformatf("single%0h", vals[k]), w);
      check($sformatf("single%0h latency", vals[k]), 32'(w), 32'd2);
    end

    // Burst of six strobes into a 4-deep FIFO
    repeat (3) @(negedge sys_clk);
    peak = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          din       = 8'(8'h10 + i);
          din_valid = 1'b1;
          @(negedge sys_clk);
          if (int'(fifo_count) > peak) peak = int'(fifo_count);
          if (i == 1) check("burst push+pop count", 32'(fifo_count), 32'd1);
        end
        din_valid = 1'b0;
        check("burst ovf", 32'(overflow), 32'd1);
        check("burst peak", 32'(peak), 32'd4);
      end
      begin
        int wf;
        for (int k = 0; k < 5; k++) begin
          expect_frame(8'(8'h10 + k), $sformatf("burst%0d", k), wf);
          if (k > 0) check($sformatf("burst%0d gap", k), 32'(DIV + wf - 1), 32'(DIV + 1));
        end
      end
    join
    repeat (DIV * NSLOT) @(negedge sys_clk);
    check("burst drained count", 32'(fifo_count), 32'd0);
    check("burst drained busy", 32'(busy), 32'd0);
    check("burst ovf sticky", 32'(overflow), 32'd1);

    // Clear without a write
    clr_overflow = 1'b1;
    @(negedge sys_clk);
    clr_overflow = 1'b0;
    check("clr ovf", 32'(overflow), 32'd0);

    // Clear coincident with a dropped write
    for (int i = 0; i < 6; i++) begin
      din          = 8'(8'h20 + i);
      din_valid    = 1'b1;
      clr_overflow = (i == 5);
      @(negedge sys_clk);
      if (i == 4) check("clr+drop pre ovf", 32'(overflow), 32'd0);
    end
    din_valid    = 1'b0;
    clr_overflow = 1'b0;
    check("clr+drop ovf", 32'(overflow), 32'd1);
    wait_idle("clr+drop");

    // Reset mid-DATA with two entries queued
    strobe(8'h00);
    strobe(8'h5A);
    strobe(8'h3C);
    repeat (8) @(negedge sys_clk);
    check("mid tx low", 32'(tx), 32'd0);
    check("mid count", 32'(fifo_count), 32'd2);
    sys_rst   = 1'b1;
    din       = 8'hFF;
    din_valid = 1'b1;
    @(negedge sys_clk);
    sys_rst   = 1'b0;
    din_valid = 1'b0;
    check("reset tx", 32'(tx), 32'd1);
    check("reset count", 32'(fifo_count), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    lows  = 0;
    busys = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    check("post reset tx low cycles", 32'(lows), 32'd0);
    check("post reset busy cycles", 32'(busys), 32'd0);
    strobe(8'h81);
    expect_frame(8'h81, "recover", w);
    check("recover latency", 32'(w), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
